// File: rtl/scaler_video_pkg.sv
// Shared types and timing helpers for the scaler video output stage.
package scaler_video_pkg;

    // Reader state: waiting for a run request, waiting for the first pixel, streaming.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // One complete raster description (active, front porch, sync, back porch per axis).
    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t TIMING_960X768 = '{
        h_active: 960,  h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29
    };

    localparam timing_t TIMING_1280X1024 = '{
        h_active: 1280, h_fp: 48, h_sync: 112, h_bp: 248,
        v_active: 1024, v_fp: 1,  v_sync: 3,   v_bp: 38
    };

    localparam timing_t TIMING_640X512 = '{
        h_active: 640,  h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 512,  v_fp: 3,  v_sync: 6,   v_bp: 29
    };

    // Clocks per line.
    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame.
    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/scaler_video_out_counter.sv
// Horizontal/vertical raster counters with decoded timing strobes.
// While hold is high the counters sit at the origin (0,0).
module video_timing_counter
    import scaler_video_pkg::*;
#(
    parameter int H_ACTIVE  = 960,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter int CNT_WIDTH = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic active,
    output logic hsync_raw,
    output logic vsync_raw,
    output logic frame_last,
    output logic blank_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_WIDTH-1:0] H_ACT      = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] H_SYNC_BEG = CNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [CNT_WIDTH-1:0] H_SYNC_END = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_WIDTH-1:0] H_LAST     = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_ACT      = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] V_SYNC_BEG = CNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [CNT_WIDTH-1:0] V_SYNC_END = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_WIDTH-1:0] V_LAST     = CNT_WIDTH'(V_TOTAL - 1);

    logic [CNT_WIDTH-1:0] h;
    logic [CNT_WIDTH-1:0] v;

    // Free-running raster position; v advances when h wraps, so vsync changes at h=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (hold) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + CNT_WIDTH'(1);
        end else begin
            h <= h + CNT_WIDTH'(1);
        end
    end

    // Decode the raster position into region strobes.
    always_comb begin
        active      = (h < H_ACT) && (v < V_ACT);
        hsync_raw   = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
        vsync_raw   = (v >= V_SYNC_BEG) && (v < V_SYNC_END);
        frame_last  = (h == H_LAST) && (v == V_LAST);
        blank_start = (h == '0) && (v == V_ACT);
    end

endmodule

// File: rtl/scaler_video_out.sv
// Display-side reader of the scaler output stream: pulls show-ahead pixels,
// produces raster timing with aligned pixel data, requests frames from the
// scaler and flags underflow when a pixel is missing in active video.
module scaler_video_out
    import scaler_video_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int H_ACTIVE   = 960,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 29,
    parameter int SYNC_POL   = 0,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [DATA_WIDTH*CHANNELS-1:0] dOut,
    input  logic                           dOutValid,
    output logic                           nextDout,
    output logic                           start,
    output logic                           vid_hs,
    output logic                           vid_vs,
    output logic                           vid_de,
    output logic [DATA_WIDTH*CHANNELS-1:0] vid_data,
    output logic                           underflow,
    input  logic                           underflow_clr,
    output logic [15:0]                    frame_cnt
);

    localparam int   PIX_W   = DATA_WIDTH * CHANNELS;
    localparam logic SYNC_ON = (SYNC_POL != 0);

    state_t state;
    state_t state_next;

    logic run;
    logic hold;
    logic active;
    logic hsync_raw;
    logic vsync_raw;
    logic frame_last;
    logic blank_start;
    logic starve;

    logic             de_p1;
    logic             hs_p1;
    logic             vs_p1;
    logic [PIX_W-1:0] data_p1;

    assign run  = (state == RUN);
    assign hold = ~run;

    video_timing_counter #(
        .H_ACTIVE  (H_ACTIVE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_ACTIVE  (V_ACTIVE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .active      (active),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .frame_last  (frame_last),
        .blank_start (blank_start)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and the frame-request pulse. The request for the next frame goes
    // out at the first blanking line so the scaler has the whole blanking interval
    // to refill; a frame in progress always runs to its last pixel.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    start      = 1'b1;
                    state_next = PRIME;
                end
            end
            PRIME: begin
                if (dOutValid) state_next = RUN;
            end
            RUN: begin
                if (blank_start) start = 1'b1;
                if (frame_last && !enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Keep the pulse quiet while reset is held even if enable is already high.
        if (rst) start = 1'b0;
    end

    // Show-ahead consume: one pixel per active clock, only when one is on offer.
    assign nextDout = run & active & dOutValid;
    assign starve   = run & active & ~dOutValid;

    // ---- stage p1: timing and pixel registered together ----
    // Registered video outputs, aligned to the pixel consumed on the previous clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_p1   <= 1'b0;
            hs_p1   <= ~SYNC_ON;
            vs_p1   <= ~SYNC_ON;
            data_p1 <= '0;
        end else begin
            de_p1   <= run & active;
            hs_p1   <= (run & hsync_raw) ? SYNC_ON : ~SYNC_ON;
            vs_p1   <= (run & vsync_raw) ? SYNC_ON : ~SYNC_ON;
            data_p1 <= nextDout ? dOut : '0;
        end
    end

    // Sticky underflow flag; a fresh starvation beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                underflow <= 1'b0;
        else if (starve)        underflow <= 1'b1;
        else if (underflow_clr) underflow <= 1'b0;
    end

    // Completed-frame counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    frame_cnt <= '0;
        else if (run && frame_last) frame_cnt <= frame_cnt + 16'd1;
    end

    assign vid_de   = de_p1;
    assign vid_hs   = hs_p1;
    assign vid_vs   = vs_p1;
    assign vid_data = data_p1;

endmodule

// File: tb/tb_scaler_video_out.sv
// Directed bench for scaler_video_out on a tiny 14x7 raster (8x4 active).
module tb_scaler_video_out;

    localparam int PIX_W = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic [PIX_W-1:0] dout;
    logic             dout_valid = 1'b0;
    logic             next_dout;
    logic             start;
    logic             vid_hs;
    logic             vid_vs;
    logic             vid_de;
    logic [PIX_W-1:0] vid_data;
    logic             underflow;
    logic             underflow_clr = 1'b0;
    logic [15:0]      frame_cnt;

    logic [PIX_W-1:0] pix;
    int errors = 0;
    int checks = 0;

    scaler_video_out #(
        .DATA_WIDTH (8),
        .CHANNELS   (3),
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (2),
        .H_BP       (2),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (1),
        .V_BP       (1),
        .SYNC_POL   (0),
        .CNT_WIDTH  (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .dOut          (dout),
        .dOutValid     (dout_valid),
        .nextDout      (next_dout),
        .start         (start),
        .vid_hs        (vid_hs),
        .vid_vs        (vid_vs),
        .vid_de        (vid_de),
        .vid_data      (vid_data),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    // Counting source: the pixel value is its index within the stream.
    always @(posedge clk or posedge rst) begin
        if (rst)            pix <= '0;
        else if (next_dout) pix <= pix + 1'b1;
    end
    assign dout = pix;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then enable with a valid source; returns 1 time unit after the edge
    // that puts the raster at (h=0, v=0) in RUN.
    task automatic bring_up();
        rst = 1'b1; enable = 1'b0; dout_valid = 1'b1; underflow_clr = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        int starts, nds, des, hs_act, vs_act;
        rst = 1'b1; enable = 1'b0; dout_valid = 1'b0; underflow_clr = 1'b0;
        tick(); tick();
        checks++; if (vid_hs !== 1'b1) begin errors++; $display("FAIL reset_hs got=%b want=1", vid_hs); end
        checks++; if (vid_vs !== 1'b1) begin errors++; $display("FAIL reset_vs got=%b want=1", vid_vs); end
        checks++; if ({vid_de, next_dout, start, underflow} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b want=0000", {vid_de, next_dout, start, underflow}); end
        checks++; if (vid_data !== 24'd0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_data got=%0d/%0d want=0/0", vid_data, frame_cnt); end
        rst = 1'b0;
        starts = 0; nds = 0; des = 0; hs_act = 0; vs_act = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (start) starts++;
            if (next_dout) nds++;
            if (vid_de) des++;
            if (vid_hs !== 1'b1) hs_act++;
            if (vid_vs !== 1'b1) vs_act++;
            tick();
        end
        checks++; if (starts + nds + des !== 0) begin errors++; $display("FAIL idle_quiet got=%0d want=0", starts + nds + des); end
        checks++; if (hs_act + vs_act !== 0) begin errors++; $display("FAIL idle_syncs got=%0d want=0", hs_act + vs_act); end
    endtask

    task automatic test_prime_start();
        int starts, busy, n;
        enable = 1'b1; dout_valid = 1'b0;
        starts = 0; busy = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (start) starts++;
            if (vid_de || next_dout) busy++;
            tick();
        end
        checks++; if (starts !== 1) begin errors++; $display("FAIL prime_start_pulses got=%0d want=1", starts); end
        checks++; if (busy !== 0) begin errors++; $display("FAIL prime_no_count got=%0d want=0", busy); end
        dout_valid = 1'b1;
        n = 0;
        while (vid_de !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL prime_de_latency got=%0d want=2", n); end
        checks++; if (vid_data !== 24'd0) begin errors++; $display("FAIL prime_first_pixel got=%0d want=0", vid_data); end
    endtask

    task automatic test_full_frame();
        int xfers, de_idx, de_bad, data_bad, hs_bad, vs_bad, hs_low, vs_low, starts, start_c;
        int p, hp, vp;
        logic de_exp, hs_exp, vs_exp;
        bring_up();
        xfers = 0; de_idx = 0; de_bad = 0; data_bad = 0; hs_bad = 0; vs_bad = 0;
        hs_low = 0; vs_low = 0; starts = 0; start_c = -1;
        for (int c = 0; c <= 98; c++) begin
            #1;
            p = c - 1;
            hp = (p < 0) ? 0 : p % 14;
            vp = (p < 0) ? 0 : p / 14;
            de_exp = (p >= 0) && (hp < 8) && (vp < 4);
            hs_exp = !((p >= 0) && (hp >= 10) && (hp < 12));
            vs_exp = !((p >= 0) && (vp == 5));
            if (c < 98 && next_dout) xfers++;
            if (start) begin starts++; start_c = c; end
            if (vid_de !== de_exp) de_bad++;
            if (vid_hs !== hs_exp) hs_bad++;
            if (vid_vs !== vs_exp) vs_bad++;
            if (vid_hs === 1'b0) hs_low++;
            if (vid_vs === 1'b0) vs_low++;
            if (de_exp) begin
                if (vid_data !== 24'(de_idx)) data_bad++;
                de_idx++;
            end else if (vid_data !== 24'd0) data_bad++;
            if (c == 97) begin
                checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL frame_cnt_before got=%0d want=0", frame_cnt); end
            end
            if (c == 98) begin
                checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL frame_cnt_after got=%0d want=1", frame_cnt); end
                checks++; if (next_dout !== 1'b1) begin errors++; $display("FAIL next_frame_no_reprime got=%b want=1", next_dout); end
            end
            if (c < 98) tick();
        end
        checks++; if (xfers !== 32) begin errors++; $display("FAIL frame_transfers got=%0d want=32", xfers); end
        checks++; if (de_bad !== 0) begin errors++; $display("FAIL frame_de got=%0d bad want=0", de_bad); end
        checks++; if (data_bad !== 0) begin errors++; $display("FAIL frame_data got=%0d bad want=0", data_bad); end
        checks++; if (hs_bad !== 0 || hs_low !== 14) begin errors++; $display("FAIL frame_hsync got=%0d bad,%0d low want=0,14", hs_bad, hs_low); end
        checks++; if (vs_bad !== 0 || vs_low !== 14) begin errors++; $display("FAIL frame_vsync got=%0d bad,%0d low want=0,14", vs_bad, vs_low); end
        checks++; if (starts !== 1 || start_c !== 56) begin errors++; $display("FAIL frame_start got=%0d@%0d want=1@56", starts, start_c); end
    endtask

    task automatic test_underflow();
        int xfers;
        bring_up();
        xfers = 0;
        for (int c = 0; c <= 100; c++) begin
            dout_valid    = !(c == 17 || c == 99);
            underflow_clr = (c == 98 || c == 99);
            #1;
            if (c < 98 && next_dout) xfers++;
            if (c == 17) begin
                checks++; if (next_dout !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL uf_gap got=%b%b want=00", next_dout, underflow); end
            end
            if (c == 18) begin
                checks++; if (vid_de !== 1'b1 || vid_data !== 24'd0) begin errors++; $display("FAIL uf_blank_pixel got=%b/%0d want=1/0", vid_de, vid_data); end
                checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%b want=1", underflow); end
            end
            if (c == 19) begin
                checks++; if (vid_data !== 24'd11) begin errors++; $display("FAIL uf_resume got=%0d want=11", vid_data); end
            end
            if (c == 98) begin
                checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b want=1", underflow); end
            end
            if (c == 99) begin
                checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b want=0", underflow); end
            end
            if (c == 100) begin
                checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins got=%b want=1", underflow); end
            end
            if (c < 100) tick();
        end
        dout_valid = 1'b1; underflow_clr = 1'b0;
        checks++; if (xfers !== 31) begin errors++; $display("FAIL uf_transfers got=%0d want=31", xfers); end
    endtask

    task automatic test_mid_frame_disable();
        int xfers, late;
        bring_up();
        xfers = 0; late = 0;
        for (int c = 0; c < 118; c++) begin
            if (c == 28) enable = 1'b0;
            #1;
            if (c < 98 && next_dout) xfers++;
            if (c >= 98 && (start || next_dout || vid_de)) late++;
            if (c == 98) begin
                checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL dis_frame_cnt got=%0d want=1", frame_cnt); end
            end
            tick();
        end
        checks++; if (xfers !== 32) begin errors++; $display("FAIL dis_transfers got=%0d want=32", xfers); end
        checks++; if (late !== 0) begin errors++; $display("FAIL dis_idle_quiet got=%0d want=0", late); end
    endtask

    task automatic test_async_reset();
        int n;
        bring_up();
        for (int c = 0; c < 19; c++) tick();
        #1;
        checks++; if (vid_de !== 1'b1 || vid_data !== 24'd12) begin errors++; $display("FAIL ar_pre got=%b/%0d want=1/12", vid_de, vid_data); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({vid_de, next_dout, start, underflow} !== 4'b0000) begin errors++; $display("FAIL ar_ctrl got=%b want=0000", {vid_de, next_dout, start, underflow}); end
        checks++; if (vid_hs !== 1'b1 || vid_vs !== 1'b1 || vid_data !== 24'd0) begin errors++; $display("FAIL ar_video got=%b%b/%0d want=11/0", vid_hs, vid_vs, vid_data); end
        enable = 1'b0; dout_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        enable = 1'b1;
        #1;
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL ar_restart got=%b want=1", start); end
        tick();
        checks++; if (start !== 1'b0 || next_dout !== 1'b0) begin errors++; $display("FAIL ar_prime got=%b%b want=00", start, next_dout); end
        dout_valid = 1'b1;
        n = 0;
        while (vid_de !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++; if (n !== 2 || vid_data !== 24'd0) begin errors++; $display("FAIL ar_first_de got=%0d/%0d want=2/0", n, vid_data); end
    endtask

    initial begin
        test_reset();
        test_prime_start();
        test_full_frame();
        test_underflow();
        test_mid_frame_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scaler_video_out.md
Name: scaler_video_out

Overview:
- Reader end of the scaler output stream: pulls scaled pixels with the scaler's show-ahead handshake (dOutValid / nextDout).
- Generates raster timing (hsync, vsync, data enable) with registered, aligned pixel data for the display / HDMI encoder.
- Issues the per-frame start pulse back to the scaler.
- Detects and flags underflow when the scaler cannot keep up.

Parameters:
- DATA_WIDTH, 8, bits per colour channel
- CHANNELS, 3, colour channels per pixel
- H_ACTIVE, 960, active pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 768, active lines
- V_FP, 3, vertical front porch in lines
- V_SYNC, 6, vsync width in lines
- V_BP, 29, vertical back porch in lines
- SYNC_POL, 0, 0 = syncs active-low, 1 = active-high
- CNT_WIDTH, 12, width of the h/v counters

Ports:
- clk, input, 1, pixel clock
- rst, input, 1, asynchronous active-high reset
- enable, input, 1, run request
- dOut, input, DATA_WIDTH*CHANNELS, scaler output pixel (show-ahead)
- dOutValid, input, 1, dOut is valid
- nextDout, output, 1, consume dOut this cycle
- start, output, 1, one-cycle frame-start pulse to the scaler
- vid_hs, output, 1, horizontal sync
- vid_vs, output, 1, vertical sync
- vid_de, output, 1, active video
- vid_data, output, DATA_WIDTH*CHANNELS, pixel, zero outside active video
- underflow, output, 1, sticky underflow flag
- underflow_clr, input, 1, clears underflow
- frame_cnt, output, 16, completed-frame count

Behaviour:
Interface and reset
- One clock, clk. Reset rst is asynchronous, active-high.
- All outputs reset to: syncs inactive (= ~SYNC_POL), vid_de=0, vid_data=0, nextDout=0, start=0, underflow=0, frame_cnt=0.
- Counters and state reset to h=0, v=0, IDLE.

Timing counters
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined the same way.
- h counts 0..H_TOTAL-1 and wraps; v increments on each h wrap and wraps at V_TOTAL-1.
- Active region: h<H_ACTIVE and v<V_ACTIVE.
- hsync: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync: the corresponding V range, whole lines, changes at h=0.

State machine
- IDLE: counters held at 0, outputs at reset values. On enable=1, pulse start for 1 cycle and go to PRIME.
- PRIME: counters held. Go to RUN on the first cycle with dOutValid=1; counting begins with h=0, v=0 on the next cycle. No timeout.
- RUN: counters free-run.
  - At h=0, v=V_ACTIVE (first blanking line), pulse start for 1 cycle so the scaler begins the next frame.
  - At the last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1), frame_cnt increments and wraps. If enable=0 at that point, go to IDLE. Otherwise continue into the next frame without re-priming.
  - enable deasserted mid-frame never truncates the frame.

Handshake
- nextDout = active region AND dOutValid AND state==RUN. It is combinational from the counters and dOutValid.
- A pixel transfers when nextDout=1; exactly one pixel per active clock.

Underflow
- Active region with dOutValid=0: vid_data=0 for that pixel, no transfer, underflow sets.
- Timing never stalls.
- underflow_clr clears the flag. A new underflow in the same cycle as underflow_clr wins (set dominates).

Latency
- vid_hs, vid_vs, vid_de and vid_data are registered: 1 clock after the counter value that produced them.
- vid_data carries the pixel transferred in the previous cycle.

Decomposition:
- Shared package scaler_video_pkg holds:
  - state enum (IDLE, PRIME, RUN);
  - H_TOTAL / V_TOTAL derivation functions;
  - a standard timing-preset constant set (960x768, 1280x1024, 640x512).
- One sub-module, video_timing_counter: h/v counters with hold input; outputs active, hsync_raw, vsync_raw, frame_last, blank_start.
- Top level holds the FSM, handshake, data register and flags.

Test Plan:
Small timing for all tests: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (H_TOTAL=14, V_TOTAL=7).
1. Reset and idle: rst pulse, enable=0 for 200 clocks -> start, nextDout and vid_de stay 0; syncs inactive.
2. Prime and start: enable=1 with dOutValid=0 for 10 clocks -> one start pulse, then no counting. Raise dOutValid -> first vid_de=1 exactly 2 clocks later.
3. Full frame with always-valid counting source (pixel value = index) -> 32 nextDout pulses per frame; vid_data sequence 0..31 with vid_de=1; hsync 2 clocks/line at h=10..11; vsync on line 5; start pulse at v=4, h=0; frame_cnt=1 after 98 clocks.
4. Underflow: drop dOutValid for pixel 3 of line 1 -> vid_data=0 there; 31 transfers; underflow=1 until underflow_clr. Underflow and underflow_clr in the same cycle -> underflow remains 1.
5. Mid-frame disable: enable=0 at v=2 -> frame completes (32 transfers), frame_cnt increments, then IDLE with no further start pulse.
6. Async reset mid-line at h=5, v=1 -> all outputs at reset values in the same cycle; a re-enable yields a fresh start pulse and a PRIME sequence.
